// File: rtl/dj8_bus_pkg.sv
// Shared types and bus widths for the DJ8 external memory bus arbiter.
package dj8_bus_pkg;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_t;

  localparam int DJ8_ADDR_W = 16;
  localparam int DJ8_DATA_W = 8;

endpackage

// File: rtl/dj8_bus_arbiter.sv
// Two-master arbiter sharing the DJ8 memory bus between the CPU (default owner)
// and a DMA requester; DMA slots are stolen by withholding the CPU clock enable.
module dj8_bus_arbiter
  import dj8_bus_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CPU_MIN   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DJ8_ADDR_W-1:0] cpu_address,
  input  logic [DJ8_DATA_W-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_write_cycle,
  output logic                  cpu_clk_en,
  output logic [DJ8_DATA_W-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic [DJ8_ADDR_W-1:0] dma_addr,
  input  logic [DJ8_DATA_W-1:0] dma_wdata,
  input  logic                  dma_write,
  output logic                  dma_gnt,
  output logic                  dma_ack,
  output logic [DJ8_DATA_W-1:0] dma_rdata,
  output logic [DJ8_ADDR_W-1:0] mem_addr,
  output logic [DJ8_DATA_W-1:0] mem_wdata,
  output logic                  mem_we_n,
  input  logic [DJ8_DATA_W-1:0] mem_rdata
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int HOLD_W  = $clog2(CPU_MIN + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(CPU_MIN - 1);

  arb_state_t                state_q;
  logic [BURST_W-1:0]        burst_cnt_q;
  logic [HOLD_W-1:0]         holdoff_cnt_q;
  logic                      cpu_clk_en_q;
  logic                      dma_gnt_q;
  logic                      dma_ack_q;
  logic [DJ8_DATA_W-1:0]     dma_rdata_q;
  logic                      take_dma;

  // A store sequence must never be split, so the CPU has to be idle on the bus.
  assign take_dma = dma_req & ~cpu_write_cycle & cpu_we & (holdoff_cnt_q == '0);

  // Arbitration FSM with registered clock-enable, grant and DMA response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_CPU;
      burst_cnt_q   <= '0;
      holdoff_cnt_q <= '0;
      cpu_clk_en_q  <= 1'b1;
      dma_gnt_q     <= 1'b0;
      dma_ack_q     <= 1'b0;
      dma_rdata_q   <= '0;
    end else begin
      dma_ack_q <= 1'b0;
      case (state_q)
        ARB_CPU: begin
          if (take_dma) begin
            state_q      <= ARB_DMA;
            burst_cnt_q  <= '0;
            cpu_clk_en_q <= 1'b0;
            dma_gnt_q    <= 1'b1;
          end else begin
            if (holdoff_cnt_q != '0) begin
              holdoff_cnt_q <= holdoff_cnt_q - HOLD_W'(1);
            end else begin
              holdoff_cnt_q <= holdoff_cnt_q;
            end
            cpu_clk_en_q <= 1'b1;
            dma_gnt_q    <= 1'b0;
          end
        end
        ARB_DMA: begin
          dma_ack_q <= 1'b1;
          if (!dma_write) begin
            dma_rdata_q <= mem_rdata;
          end else begin
            dma_rdata_q <= dma_rdata_q;
          end
          if (dma_req && (burst_cnt_q < BURST_LAST)) begin
            burst_cnt_q  <= burst_cnt_q + BURST_W'(1);
            cpu_clk_en_q <= 1'b0;
            dma_gnt_q    <= 1'b1;
          end else begin
            state_q       <= ARB_CPU;
            holdoff_cnt_q <= HOLD_INIT;
            cpu_clk_en_q  <= 1'b1;
            dma_gnt_q     <= 1'b0;
          end
        end
        default: begin
          state_q      <= ARB_CPU;
          cpu_clk_en_q <= 1'b1;
          dma_gnt_q    <= 1'b0;
        end
      endcase
    end
  end

  // Bus mux: the frozen CPU keeps its outputs stable while the DMA drives the bus.
  always_comb begin
    mem_addr  = cpu_address;
    mem_wdata = cpu_wdata;
    mem_we_n  = cpu_we;
    if (state_q == ARB_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we_n  = ~dma_write;
    end else begin
      mem_addr  = cpu_address;
      mem_wdata = cpu_wdata;
      mem_we_n  = cpu_we;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_clk_en = cpu_clk_en_q;
  assign dma_gnt    = dma_gnt_q;
  assign dma_ack    = dma_ack_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dj8_bus_arbiter.sv
// Bench for dj8_bus_arbiter: directed scenarios plus random traffic, checked
// against a slot-level ownership model and a reference memory image.
module tb_dj8_bus_arbiter;

  localparam int MAX_BURST = 4;
  localparam int CPU_MIN   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_write_cycle;
  logic        cpu_clk_en;
  logic [7:0]  cpu_rdata;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_write;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we_n;
  logic [7:0]  mem_rdata;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int checks;
  int failures;

  // Model: who owns the current slot, how long the burst / CPU run has lasted.
  bit         m_dma;
  int         m_burst;
  int         m_cpu_run;
  bit         m_ack;
  logic [7:0] m_rdata;

  dj8_bus_arbiter #(.MAX_BURST(MAX_BURST), .CPU_MIN(CPU_MIN)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_write_cycle(cpu_write_cycle), .cpu_clk_en(cpu_clk_en), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_write(dma_write),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!reset && !mem_we_n) mem[mem_addr] <= mem_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dma     = 1'b0;
    m_burst   = 0;
    m_cpu_run = CPU_MIN;
    m_ack     = 1'b0;
    m_rdata   = 8'h00;
  endtask

  // Check the slot in progress, advance the model by one slot, move to the next negedge.
  task automatic step();
    logic [15:0] ea;
    logic [7:0]  ew;
    logic        ewe;
    #1;
    ea  = m_dma ? dma_addr  : cpu_address;
    ew  = m_dma ? dma_wdata : cpu_wdata;
    ewe = m_dma ? ~dma_write : cpu_we;
    check_val("mem_addr",   32'(mem_addr),   32'(ea));
    check_val("mem_wdata",  32'(mem_wdata),  32'(ew));
    check_val("mem_we_n",   32'(mem_we_n),   32'(ewe));
    check_val("cpu_clk_en", 32'(cpu_clk_en), 32'(!m_dma));
    check_val("dma_gnt",    32'(dma_gnt),    32'(m_dma));
    check_val("dma_ack",    32'(dma_ack),    32'(m_ack));
    check_val("dma_rdata",  32'(dma_rdata),  32'(m_rdata));
    check_val("cpu_rdata",  32'(cpu_rdata),  32'(ref_mem[ea]));
    if (m_dma) begin
      if (dma_write) ref_mem[dma_addr] = dma_wdata;
      else m_rdata = ref_mem[dma_addr];
      m_ack = 1'b1;
      if (dma_req && m_burst < MAX_BURST) m_burst++;
      else begin
        m_dma     = 1'b0;
        m_cpu_run = 0;
      end
    end else begin
      if (!cpu_we) ref_mem[cpu_address] = cpu_wdata;
      m_ack = 1'b0;
      m_cpu_run++;
      if (dma_req && !cpu_write_cycle && cpu_we && m_cpu_run >= CPU_MIN) begin
        m_dma   = 1'b1;
        m_burst = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_grant(input int limit);
    for (int i = 0; i < limit && !m_dma; i++) step();
    if (!m_dma) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout: no DMA slot within %0d slots", limit);
    end
  endtask

  task automatic drain();
    dma_req   = 1'b0;
    dma_write = 1'b0;
    for (int i = 0; i < 8 && m_dma; i++) step();
    step();
    step();
  endtask

  task automatic new_req();
    dma_addr  = 16'($urandom_range(0, 255));
    dma_wdata = 8'($urandom);
    dma_write = 1'($urandom_range(0, 1));
    dma_req   = 1'b1;
  endtask

  int n_dma;
  int n_ack;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    reset = 1'b1;
    cpu_address = 16'h8000; cpu_wdata = 8'h00; cpu_we = 1'b1; cpu_write_cycle = 1'b0;
    dma_req = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00; dma_write = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_clk_en", 32'(cpu_clk_en), 32'd1);
    check_val("rst_gnt",    32'(dma_gnt),    32'd0);
    check_val("rst_ack",    32'(dma_ack),    32'd0);
    check_val("rst_rdata",  32'(dma_rdata),  32'd0);
    check_val("rst_we_n",   32'(mem_we_n),   32'd1);
    @(negedge clk);
    reset = 1'b0;

    // CPU fetches with no DMA traffic
    step();
    cpu_address = 16'h8001;
    step();

    // Single read of 0x1234
    mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
    dma_addr = 16'h1234; dma_write = 1'b0; dma_req = 1'b1;
    wait_grant(8);
    step();
    #1;
    check_val("dir_read_rdata", 32'(dma_rdata), 32'hA5);
    check_val("dir_read_addr_cpu", 32'(cpu_address), 32'h8001);
    drain();

    // Single write of 0x3C to 0x0100
    dma_addr = 16'h0100; dma_wdata = 8'h3C; dma_write = 1'b1; dma_req = 1'b1;
    wait_grant(8);
    step();
    drain();
    check_val("dir_write_mem", 32'(mem[16'h0100]), 32'h3C);

    // Held request: 4 DMA slots then 2 CPU slots, repeating
    dma_addr = 16'h0010; dma_write = 1'b0; dma_req = 1'b1;
    wait_grant(8);
    n_dma = 0; n_ack = 0;
    for (int i = 0; i < 18; i++) begin
      #1;
      if (!cpu_clk_en) n_dma++;
      if (dma_ack) n_ack++;
      step();
    end
    check_val("burst_dma_slots", 32'(n_dma), 32'd12);
    check_val("burst_acks",      32'(n_ack), 32'd12);
    drain();

    // Request raised during a CPU store
    cpu_address = 16'h0200; cpu_wdata = 8'h77; cpu_we = 1'b0; cpu_write_cycle = 1'b1;
    dma_addr = 16'h0020; dma_write = 1'b0; dma_req = 1'b1;
    repeat (3) step();
    cpu_we = 1'b1;
    step();
    cpu_write_cycle = 1'b0;
    wait_grant(8);
    check_val("store_mem", 32'(mem[16'h0200]), 32'h77);
    drain();

    // Async reset in the second slot of a burst
    dma_addr = 16'h0030; dma_write = 1'b0; dma_req = 1'b1;
    wait_grant(8);
    step();
    reset = 1'b1;
    #1;
    check_val("mid_rst_clk_en", 32'(cpu_clk_en), 32'd1);
    check_val("mid_rst_gnt",    32'(dma_gnt),    32'd0);
    check_val("mid_rst_ack",    32'(dma_ack),    32'd0);
    check_val("mid_rst_rdata",  32'(dma_rdata),  32'd0);
    check_val("mid_rst_addr",   32'(mem_addr),   32'(cpu_address));
    dma_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!m_dma) begin
        cpu_write_cycle = ($urandom_range(0, 3) == 0);
        cpu_we          = cpu_write_cycle ? 1'($urandom_range(0, 1)) : 1'b1;
        cpu_address     = 16'($urandom_range(0, 255));
        cpu_wdata       = 8'($urandom);
      end
      if (dma_req && m_ack) begin
        if ($urandom_range(0, 1) == 1) new_req();
        else dma_req = 1'b0;
      end else if (!dma_req && $urandom_range(0, 3) == 0) begin
        new_req();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
